// File: rtl/ssd_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display, double-buffered per frame.
// Latency: outputs are registered and lag the internal state/idx by one clk.
// Backpressure: none; load is always accepted and last-wins until the next frame boundary.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    load_ack,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic [IW-1:0]                  idx;
    logic [NUM_DIGITS-1:0][3:0]     data_disp;
    logic [NUM_DIGITS-1:0][3:0]     data_shd;
    logic [NUM_DIGITS-1:0]          dp_disp;
    logic [NUM_DIGITS-1:0]          dp_shd;
    logic [NUM_DIGITS-1:0]          en_disp;
    logic [NUM_DIGITS-1:0]          en_shd;
    logic                           pending;
    logic                           boundary;

    // Last cycle of the last digit's SHOW slot: the next edge starts a new frame.
    assign boundary = (state == ST_SHOW) && (cnt == SHOW_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            an_n       <= '1;
            dp_n       <= 1'b1;
            hex_out    <= '0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            data_disp  <= '0;
            data_shd   <= '0;
            dp_disp    <= '0;
            dp_shd     <= '0;
            en_disp    <= '0;
            en_shd     <= '0;
            pending    <= 1'b0;
        end else begin
            load_ack   <= 1'b0;
            frame_tick <= boundary;

            // Output stage follows the state held before this edge.
            an_n <= '1;
            dp_n <= 1'b1;
            if (state == ST_SHOW) begin
                an_n[idx] <= ~en_disp[idx];
                hex_out   <= data_disp[idx];
                dp_n      <= ~(dp_disp[idx] & en_disp[idx]);
            end

            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= ST_SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase

            if (load) begin
                data_shd <= data_in;
                dp_shd   <= dp_in;
                en_shd   <= digit_en;
                pending  <= 1'b1;
            end

            // A load on the boundary edge itself bypasses the shadow.
            if (boundary) begin
                if (load) begin
                    data_disp <= data_in;
                    dp_disp   <= dp_in;
                    en_disp   <= digit_en;
                    pending   <= 1'b0;
                    load_ack  <= 1'b1;
                end else if (pending) begin
                    data_disp <= data_shd;
                    dp_disp   <= dp_shd;
                    en_disp   <= en_shd;
                    pending   <= 1'b0;
                    load_ack  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized + directed bench for ssd_scan_ctrl with a frame-position reference model and output scoreboard.
module tb_ssd_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int B     = 2;
    localparam int SLOT  = R + B;
    localparam int FRAME = N * SLOT;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] data_in  = '0;
    logic [3:0]  dp_in    = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  hex_out;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        load_ack;
    logic        frame_tick;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .hex_out   (hex_out),
        .an_n      (an_n),
        .dp_n      (dp_n),
        .load_ack  (load_ack),
        .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] an;
        logic       dp;
        logic       ack;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: position within the frame plus the value shown in the current frame
    int          pos;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_en, m_hex;
    logic        win;
    logic [15:0] w_data;
    logic [3:0]  w_dp, w_en;

    task automatic step(input logic r, input logic l, input logic [15:0] d,
                        input logic [3:0] p, input logic [3:0] e);
        exp_t x;
        int   s;
        int   qq;
        rst_n    = r;
        load     = l;
        data_in  = d;
        dp_in    = p;
        digit_en = e;
        @(posedge clk);
        #1;
        if (!r) begin
            pos    = 0;
            m_data = '0;
            m_dp   = '0;
            m_en   = '0;
            m_hex  = '0;
            win    = 1'b0;
            x      = '{hex: 4'h0, an: 4'hF, dp: 1'b1, ack: 1'b0, tick: 1'b0};
        end else begin
            s    = pos / SLOT;
            qq   = pos % SLOT;
            x.an = 4'hF;
            x.dp = 1'b1;
            if (qq >= B) begin
                m_hex   = m_data[4*s +: 4];
                x.an[s] = ~m_en[s];
                x.dp    = ~(m_dp[s] & m_en[s]);
            end
            x.hex  = m_hex;
            x.tick = (pos == FRAME - 1);
            x.ack  = 1'b0;
            if (l) begin
                win    = 1'b1;
                w_data = d;
                w_dp   = p;
                w_en   = e;
            end
            if (pos == FRAME - 1) begin
                x.ack = win;
                if (win) begin
                    m_data = w_data;
                    m_dp   = w_dp;
                    m_en   = w_en;
                end
                win = 1'b0;
            end
            pos = (pos + 1) % FRAME;
        end
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic idle_until(input int p);
        for (int i = 0; i < FRAME && pos != p; i++)
            idle(1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        step(1'b1, 1'b1, d, p, e);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hex_out", hex_out, e.hex);
                chk("an_n", an_n, e.an);
                chk("dp_n", {3'b0, dp_n}, {3'b0, e.dp});
                chk("load_ack", {3'b0, load_ack}, {3'b0, e.ack});
                chk("frame_tick", {3'b0, frame_tick}, {3'b0, e.tick});
                checks++;
                if ($countones(~an_n) <= 1) passed++;
                else $display("FAIL an_onehot: an_n=%b has more than one low bit at %0t", an_n, $time);
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(10);
        do_load(16'h1234, 4'b0100, 4'hF);
        idle(2 * FRAME);

        idle_until(5);
        do_load(16'hAAAA, 4'h0, 4'hF);
        idle(3);
        do_load(16'h5555, 4'h0, 4'hF);
        idle(FRAME + 4);

        idle_until(FRAME - 1);
        do_load(16'hBEEF, 4'b1000, 4'hF);
        idle(FRAME + 6);

        idle_until(7);
        do_load(16'hC3A5, 4'b1111, 4'b0101);
        idle(2 * FRAME);

        idle_until(3);
        do_load(16'h9876, 4'b0011, 4'hF);
        idle_until(2 * SLOT + B + 1);
        step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0)
                step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                step(1'b1, ($urandom_range(0, 15) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
